// File: rtl/bram_ecc_check_scrub_pkg.sv
// bram_ecc_check_scrub_pkg: shared types and helpers for the 64-bit BRAM ECC (Xilinx layout) read path.
package bram_ecc_check_scrub_pkg;

    localparam int ECC_MAX_POS = 71;

    typedef logic [7:0] ecc_syn_t;

    typedef enum logic [1:0] {ECC_OK, ECC_CE_DATA, ECC_CE_CHK, ECC_UE} ecc_status_t;

    typedef struct packed {
        ecc_status_t status;
        logic [5:0]  idx;
    } ecc_class_t;

    typedef enum logic {SB_EMPTY, SB_FULL} sb_state_t;

    // Hamming check bits over codeword positions 1..71 plus overall parity in bit 7.
    function automatic logic [7:0] ecc_encode(input logic [63:0] d);
        logic [7:0] e;
        int pos;
        e = '0;
        for (int j = 0; j < 64; j++) begin
            pos = j + 3;
            for (int i = 2; i < 7; i++) if (pos >= (1 << i)) pos++;
            if (d[j]) e[6:0] = e[6:0] ^ 7'(pos);
        end
        e[7] = ^{d, e[6:0]};
        return e;
    endfunction

    // syn[7] is overall parity, syn[6:0] the Hamming syndrome; idx is the data bit at position s.
    function automatic ecc_class_t ecc_classify(input ecc_syn_t syn);
        ecc_class_t c;
        logic [6:0] s;
        logic [6:0] n;
        s = syn[6:0];
        n = s - 7'd1;
        for (int i = 0; i < 7; i++) if (s > 7'(1 << i)) n = n - 7'd1;
        c.idx = n[5:0];
        if (!syn[7]) c.status = (s == '0) ? ECC_OK : ECC_UE;
        else if ((s & (s - 7'd1)) == '0) c.status = ECC_CE_CHK;
        else if (int'(s) > ECC_MAX_POS) c.status = ECC_UE;
        else c.status = ECC_CE_DATA;
        return c;
    endfunction

endpackage

// File: rtl/bram_ecc_check_scrub_scrub_buf.sv
// ecc_scrub_buf: single-entry req/ack holding register for scrub write-backs with drop detection.
module ecc_scrub_buf
    import bram_ecc_check_scrub_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  gclk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [63:0]           load_data,
    input  logic [7:0]            load_ecc,
    input  logic                  sc_ack,
    input  logic                  cnt_clr,
    output logic                  sc_req,
    output logic [ADDR_WIDTH-1:0] sc_addr,
    output logic [63:0]           sc_data,
    output logic [7:0]            sc_ecc,
    output logic                  sc_drop
);

    sb_state_t state, state_next;
    logic take;
    logic drop;

    // State register.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) state <= SB_EMPTY;
        else state <= state_next;
    end

    // A new entry is taken when empty or when the held one is acked in the same cycle.
    always_comb begin
        take = load && (state == SB_EMPTY || sc_ack);
        drop = load && state == SB_FULL && !sc_ack;
        state_next = take ? SB_FULL : (sc_ack ? SB_EMPTY : state);
    end

    // Payload only changes on a take, so it stays stable while sc_req is high.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            sc_addr <= '0;
            sc_data <= '0;
            sc_ecc  <= '0;
        end else if (take) begin
            sc_addr <= load_addr;
            sc_data <= load_data;
            sc_ecc  <= load_ecc;
        end
    end

    // Sticky drop flag; clearing wins over a new drop.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) sc_drop <= 1'b0;
        else if (cnt_clr) sc_drop <= 1'b0;
        else if (drop) sc_drop <= 1'b1;
    end

    assign sc_req = (state == SB_FULL);

endmodule

// File: rtl/bram_ecc_check_scrub.sv
// bram_ecc_check_scrub: 2-stage ECC check/correct of BRAM reads with scrub write-back queue and event counters.
module bram_ecc_check_scrub
    import bram_ecc_check_scrub_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  gclk,
    input  logic                  rstn,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [63:0]           rd_data,
    input  logic [7:0]            rd_ecc,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [63:0]           out_data,
    output logic                  out_ce,
    output logic                  out_ue,
    output logic                  sc_req,
    output logic [ADDR_WIDTH-1:0] sc_addr,
    output logic [63:0]           sc_data,
    output logic [7:0]            sc_ecc,
    input  logic                  sc_ack,
    output logic                  sc_drop,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  ce_cnt,
    output logic [CNT_WIDTH-1:0]  ue_cnt
);

    logic                  v1;
    logic [ADDR_WIDTH-1:0] a1;
    logic [63:0]           d1;
    ecc_syn_t              syn1;
    logic [7:0]            rd_enc;
    logic [7:0]            out_enc;
    ecc_class_t            cls;
    logic [63:0]           fixed;

    assign rd_enc = ecc_encode(rd_data);

    // Stage 1: capture the read and form syndrome plus overall parity.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            v1   <= 1'b0;
            a1   <= '0;
            d1   <= '0;
            syn1 <= '0;
        end else begin
            v1   <= rd_valid;
            a1   <= rd_addr;
            d1   <= rd_data;
            syn1 <= {^{rd_data, rd_ecc}, rd_enc[6:0] ^ rd_ecc[6:0]};
        end
    end

    assign cls   = ecc_classify(syn1);
    assign fixed = d1 ^ ((cls.status == ECC_CE_DATA) ? (64'd1 << cls.idx) : 64'd0);

    // Stage 2: classify and correct; flags are qualified by valid.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_ce    <= 1'b0;
            out_ue    <= 1'b0;
        end else begin
            out_valid <= v1;
            out_addr  <= a1;
            out_data  <= fixed;
            out_ce    <= v1 && (cls.status == ECC_CE_DATA || cls.status == ECC_CE_CHK);
            out_ue    <= v1 && (cls.status == ECC_UE);
        end
    end

    // Saturating event counters; clear beats increment.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else if (cnt_clr) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else begin
            if (out_valid && out_ce && !(&ce_cnt)) ce_cnt <= ce_cnt + CNT_WIDTH'(1);
            if (out_valid && out_ue && !(&ue_cnt)) ue_cnt <= ue_cnt + CNT_WIDTH'(1);
        end
    end

    assign out_enc = ecc_encode(out_data);

    ecc_scrub_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_scrub_buf (
        .gclk      (gclk),
        .rstn      (rstn),
        .load      (out_valid && out_ce),
        .load_addr (out_addr),
        .load_data (out_data),
        .load_ecc  (out_enc),
        .sc_ack    (sc_ack),
        .cnt_clr   (cnt_clr),
        .sc_req    (sc_req),
        .sc_addr   (sc_addr),
        .sc_data   (sc_data),
        .sc_ecc    (sc_ecc),
        .sc_drop   (sc_drop)
    );

endmodule
